ft245_responder: RTL and testbench

FT245_RESPONDER -- requirements
Module: ft245_responder

---
 rtl/ft245_pkg.sv | 14 +
 rtl/ft245_resp_fifo.sv | 46 ++++
 rtl/ft245_responder.sv | 116 +++++++++++
 tb/tb_ft245_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared widths, default queue depth and read-side state encoding for the
// FT245-style responder.
package ft245_pkg;
  localparam int unsigned FT_DATA_W     = 32;
  localparam int unsigned FT_BE_W       = 4;
  localparam int unsigned FT_WORD_W     = FT_DATA_W + FT_BE_W;
  localparam int unsigned FT_DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_TURN  = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_t;
endpackage

// File: rtl/ft245_resp_fifo.sv
// Synchronous FIFO with occupancy count. Push is ignored when full and pop is
// ignored when empty. The head word is visible with zero latency.
module ft245_resp_fifo #(
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ft245_responder.sv
// FT245-style responder: host<->FPGA word queues behind a shared tri-state bus.
// Define FT245_RESP_STATS_EN to add saturating drop/underrun counters.
module ft245_responder
  import ft245_pkg::*;
#(
  parameter int unsigned ADDR_W = FT_DEF_ADDR_W
) (
  input  logic                 usb_clk,
  input  logic                 rst_n,
  output logic                 usb_rxf,
  output logic                 usb_txe,
  input  logic                 usb_wr,
  input  logic                 usb_rd,
  input  logic                 usb_oe,
  inout  tri   [FT_DATA_W-1:0] usb_data,
  inout  tri   [FT_BE_W-1:0]   usb_be,
  input  logic                 host_tx_valid,
  output logic                 host_tx_ready,
  input  logic [FT_DATA_W-1:0] host_tx_data,
  input  logic [FT_BE_W-1:0]   host_tx_be,
  output logic                 host_rx_valid,
  input  logic                 host_rx_ready,
  output logic [FT_DATA_W-1:0] host_rx_data,
  output logic [FT_BE_W-1:0]   host_rx_be
`ifdef FT245_RESP_STATS_EN
  ,
  output logic [15:0]          stat_wr_drop,
  output logic [15:0]          stat_rd_underrun
`endif
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] TXE_LEVEL = (ADDR_W+1)'(DEPTH-1);

  rd_state_t state, state_next;

  logic                 dn_push, dn_pop, dn_full, dn_empty;
  logic [FT_WORD_W-1:0] dn_head;
  logic [ADDR_W:0]      dn_count, dn_level;
  logic                 up_push, up_pop, up_full, up_empty;
  logic [FT_WORD_W-1:0] up_head;
  logic [ADDR_W:0]      up_count;
  logic                 drive, wr_attempt, rd_underrun;
  logic [FT_WORD_W-1:0] last_word, bus_word;

  ft245_resp_fifo #(.WIDTH(FT_WORD_W), .ADDR_W(ADDR_W)) u_dnq (
    .clk(usb_clk), .rst_n(rst_n), .push(dn_push), .wdata({host_tx_be, host_tx_data}),
    .pop(dn_pop), .head(dn_head), .count(dn_count), .full(dn_full), .empty(dn_empty)
  );

  ft245_resp_fifo #(.WIDTH(FT_WORD_W), .ADDR_W(ADDR_W)) u_upq (
    .clk(usb_clk), .rst_n(rst_n), .push(up_push), .wdata({usb_be, usb_data}),
    .pop(up_pop), .head(up_head), .count(up_count), .full(up_full), .empty(up_empty)
  );

  assign host_tx_ready = rst_n && !dn_full;
  assign dn_push       = host_tx_valid && host_tx_ready;
  assign drive         = (state == RD_DRIVE);
  assign dn_pop        = drive && !usb_rd && !dn_empty;
  assign rd_underrun   = drive && !usb_rd && dn_empty;
  assign dn_level      = dn_count + (ADDR_W+1)'(dn_push) - (ADDR_W+1)'(dn_pop);

  // A write while a read turnaround is requested is ignored; the read side owns the bus.
  assign wr_attempt    = !usb_wr && usb_oe;
  assign up_push       = wr_attempt && !usb_txe && !up_full;
  assign host_rx_valid = !up_empty;
  assign up_pop        = host_rx_valid && host_rx_ready;
  assign {host_rx_be, host_rx_data} = up_head;

  assign bus_word = dn_empty ? last_word : dn_head;
  assign usb_data = drive ? bus_word[FT_DATA_W-1:0] : 'z;
  assign usb_be   = drive ? bus_word[FT_WORD_W-1:FT_DATA_W] : 'z;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:  if (!usb_rxf) state_next = RD_TURN;
      RD_TURN:  state_next = RD_DRIVE;
      RD_DRIVE: if (rd_underrun) state_next = RD_IDLE;
      default:  state_next = RD_IDLE;
    endcase
    if (usb_oe) state_next = RD_IDLE;
  end

  // usb_txe follows the pre-update count, giving the writer one cycle of strobe slack.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      usb_rxf   <= 1'b1;
      usb_txe   <= 1'b0;
      last_word <= '0;
    end else begin
      usb_rxf <= (dn_level == '0);
      usb_txe <= (up_count >= TXE_LEVEL);
      if (dn_pop) last_word <= dn_head;
    end
  end

`ifdef FT245_RESP_STATS_EN
  logic wr_drop;
  assign wr_drop = wr_attempt && (usb_txe || up_full);

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_drop     <= '0;
      stat_rd_underrun <= '0;
    end else begin
      if (wr_drop && (stat_wr_drop != '1))         stat_wr_drop     <= stat_wr_drop + 16'd1;
      if (rd_underrun && (stat_rd_underrun != '1)) stat_rd_underrun <= stat_rd_underrun + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ft245_responder.sv
// Scoreboard bench for ft245_responder: directed scenarios plus random traffic
// checked against queue-based reference behaviour.
module tb_ft245_responder;
  localparam int DEPTH = 16;
  localparam logic [35:0] BUS_Z = 36'hF_FFFF_FFFF;

  logic        usb_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        usb_wr = 1'b1, usb_rd = 1'b1, usb_oe = 1'b1;
  logic        usb_rxf, usb_txe;
  tri1 [31:0]  usb_data;
  tri1 [3:0]   usb_be;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = '0;
  logic [3:0]  tb_be = '0;
  logic        host_tx_valid = 1'b0, host_tx_ready;
  logic [31:0] host_tx_data = '0;
  logic [3:0]  host_tx_be = '0;
  logic        host_rx_valid, host_rx_ready = 1'b0;
  logic [31:0] host_rx_data;
  logic [3:0]  host_rx_be;
`ifdef FT245_RESP_STATS_EN
  logic [15:0] stat_wr_drop, stat_rd_underrun;
`endif

  assign usb_data = tb_drv ? tb_data : 'z;
  assign usb_be   = tb_drv ? tb_be : 'z;

  ft245_responder #(.ADDR_W(4)) dut (
    .usb_clk(usb_clk), .rst_n(rst_n), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_wr(usb_wr), .usb_rd(usb_rd), .usb_oe(usb_oe), .usb_data(usb_data), .usb_be(usb_be),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_tx_data(host_tx_data), .host_tx_be(host_tx_be),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_rx_data(host_rx_data), .host_rx_be(host_rx_be)
`ifdef FT245_RESP_STATS_EN
    , .stat_wr_drop(stat_wr_drop), .stat_rd_underrun(stat_rd_underrun)
`endif
  );

  always #5 usb_clk = ~usb_clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain queues for both directions plus the read-window age
  // (edges since the FPGA asked for the bus with data pending).
  logic [35:0] dn_q[$];
  logic [35:0] up_q[$];
  logic [35:0] last_m = '0;
  bit          rxf_m = 1'b1, txe_m = 1'b0;
  int          age = 0, drops_m = 0, under_m = 0, dn_pops = 0, up_pops = 0;

  always @(negedge usb_clk) begin : monitor
    bit drv_m, tx_push, rd_pop, under, wr_att, wr_ok, rx_pop;
    int up_sz0;
    if (!rst_n) begin
      dn_q.delete(); up_q.delete();
      rxf_m = 1'b1; txe_m = 1'b0; age = 0; drops_m = 0; under_m = 0;
      chk("rst_rxf", usb_rxf, 1'b1);
      chk("rst_txe", usb_txe, 1'b0);
      chk("rst_tx_ready", host_tx_ready, 1'b0);
      chk("rst_rx_valid", host_rx_valid, 1'b0);
      chk("rst_bus_z", {usb_be, usb_data}, BUS_Z);
    end else begin
      drv_m = (age >= 2);
      chk("rxf", usb_rxf, rxf_m);
      chk("txe", usb_txe, txe_m);
      chk("tx_ready", host_tx_ready, dn_q.size() < DEPTH);
      chk("rx_valid", host_rx_valid, up_q.size() != 0);
      if (up_q.size() != 0) chk("rx_word", {host_rx_be, host_rx_data}, up_q[0]);
      if (drv_m) chk("bus_word", {usb_be, usb_data}, (dn_q.size() != 0) ? dn_q[0] : last_m);
      else if (!tb_drv) chk("bus_z", {usb_be, usb_data}, BUS_Z);
`ifdef FT245_RESP_STATS_EN
      chk("stat_wr_drop", stat_wr_drop, drops_m);
      chk("stat_rd_underrun", stat_rd_underrun, under_m);
`endif
      tx_push = host_tx_valid && (dn_q.size() < DEPTH);
      rd_pop  = drv_m && !usb_rd && (dn_q.size() != 0);
      under   = drv_m && !usb_rd && (dn_q.size() == 0);
      wr_att  = !usb_wr && usb_oe;
      wr_ok   = wr_att && !txe_m && (up_q.size() < DEPTH);
      rx_pop  = host_rx_ready && (up_q.size() != 0);
      up_sz0  = up_q.size();
      if (rd_pop) begin last_m = dn_q.pop_front(); dn_pops++; end
      if (tx_push) dn_q.push_back({host_tx_be, host_tx_data});
      if (rx_pop) begin void'(up_q.pop_front()); up_pops++; end
      if (wr_ok) up_q.push_back({usb_be, usb_data});
      if (wr_att && !wr_ok) drops_m++;
      if (under) under_m++;
      if (usb_oe)        age = 0;
      else if (age == 0) age = rxf_m ? 0 : 1;
      else if (age == 1) age = 2;
      else if (under)    age = 0;
      rxf_m = (dn_q.size() == 0);
      txe_m = (up_sz0 >= DEPTH - 1);
    end
  end

  task automatic cyc();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic fpga_write(input logic [31:0] d, input logic [3:0] b);
    usb_wr = 1'b0; tb_drv = 1'b1; tb_data = d; tb_be = b;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev_oe;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Four host words, turnaround, four reads, then an underrun read.
    for (int i = 0; i < 4; i++) begin
      host_tx_valid = 1'b1;
      host_tx_data  = 32'h1111_1111 * (i + 1);
      host_tx_be    = 4'(1 << i);
      cyc();
    end
    host_tx_valid = 1'b0;
    usb_oe = 1'b0;
    cyc(); cyc();
    usb_rd = 1'b0;
    repeat (4) cyc();
    usb_rd = 1'b1;
    chk("req038_rxf_high", usb_rxf, 1'b1);
    cyc();
    usb_rd = 1'b0;
    cyc();
    usb_rd = 1'b1;
    cyc();
    chk("req041_bus_z", {usb_be, usb_data}, BUS_Z);
`ifdef FT245_RESP_STATS_EN
    chk("req041_underrun", stat_rd_underrun, 16'd1);
`endif
    usb_oe = 1'b1;
    cyc();

    // Continuous writes into UPQ with no host pops; last two must be dropped.
    for (int i = 0; i < 18; i++) fpga_write(32'hA000_0000 + i, 4'(i));
    usb_wr = 1'b1; tb_drv = 1'b0;
    cyc();
    chk("req039_txe", usb_txe, 1'b1);
`ifdef FT245_RESP_STATS_EN
    chk("req039_drops", stat_wr_drop, 16'd2);
`endif

    // Bring UPQ to DEPTH-1 with txe low, then push and pop in the same cycle.
    host_rx_ready = 1'b1;
    cyc(); cyc();
    host_rx_ready = 1'b0;
    cyc();
    fpga_write(32'hBEEF_0001, 4'h3);
    host_rx_ready = 1'b1;
    fpga_write(32'hBEEF_0002, 4'hC);
    host_rx_ready = 1'b0;
    usb_wr = 1'b1; tb_drv = 1'b0;
    cyc();
    chk("req040_valid", host_rx_valid, 1'b1);
`ifdef FT245_RESP_STATS_EN
    chk("req040_no_drop", stat_wr_drop, 16'd2);
`endif
    host_rx_ready = 1'b1;
    repeat (20) cyc();
    host_rx_ready = 1'b0;

    // Reset while driving with three words still queued.
    for (int i = 0; i < 5; i++) begin
      host_tx_valid = 1'b1; host_tx_data = $urandom; host_tx_be = 4'($urandom);
      cyc();
    end
    host_tx_valid = 1'b0;
    usb_oe = 1'b0;
    cyc(); cyc();
    usb_rd = 1'b0;
    cyc(); cyc();
    usb_rd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("req042_bus_z", {usb_be, usb_data}, BUS_Z);
    chk("req042_rxf", usb_rxf, 1'b1);
    cyc(); cyc();
    rst_n = 1'b1;
    usb_rd = 1'b0;
    repeat (5) cyc();
    chk("req042_no_data", usb_rxf, 1'b1);
    usb_rd = 1'b1; usb_oe = 1'b1;
    cyc();

    // Random traffic on both queues; the bench only drives the bus when the
    // responder has certainly released it.
    dn_pops = 0; up_pops = 0;
    prev_oe = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      host_tx_valid = 1'($urandom_range(0, 1));
      host_tx_data  = $urandom;
      host_tx_be    = 4'($urandom);
      host_rx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) usb_oe = ~usb_oe;
      usb_rd = 1'($urandom_range(0, 1));
      if (usb_oe && prev_oe) begin
        usb_wr  = 1'($urandom_range(0, 1));
        tb_drv  = !usb_wr;
        tb_data = $urandom;
        tb_be   = 4'($urandom);
      end else begin
        usb_wr = ($urandom_range(0, 3) != 0);
        tb_drv = 1'b0;
      end
      prev_oe = usb_oe;
      cyc();
    end

    usb_wr = 1'b1; tb_drv = 1'b0; usb_rd = 1'b1; usb_oe = 1'b1;
    host_tx_valid = 1'b0; host_rx_ready = 1'b1;
    repeat (20) cyc();
    usb_oe = 1'b0; usb_rd = 1'b0;
    repeat (40) cyc();
    usb_oe = 1'b1; usb_rd = 1'b1;
    repeat (3) cyc();
    chk("req043_dn_streamed", dn_pops >= 2 * DEPTH + 3, 1'b1);
    chk("req043_up_streamed", up_pops >= 2 * DEPTH + 3, 1'b1);
    chk("end_rxf", usb_rxf, 1'b1);
    chk("end_rx_valid", host_rx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
